conv_window_gen: RTL and testbench

- Streaming 3x3 sample-window generator for the AHB convolver. It is the producing end of the multiplier/adder interface.
- Accepts one 4-bit pixel per handshake, in raster order.
- Keeps two row line buffers plus a 3x3 window register.
- Presents each complete, valid 3x3 neighbourhood as a packed 36-bit sample word with a one-cycle conv_en pulse, which the mult/add stage consumes directly.

---
 rtl/conv_window_gen.sv | 150 +++++++++++++++
 tb/tb_conv_window_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, packed 36-bit
// neighbourhoods out with a one-cycle conv_en strobe per complete window.
module conv_window_gen #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        frame_start,
  input  logic [3:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [35:0] sample_out,
  output logic        conv_en,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   col_r;
  logic [RW-1:0]   row_r;
  logic [3:0]      lb0_r [IMG_WIDTH];
  logic [3:0]      lb1_r [IMG_WIDTH];
  logic [35:0]     win_r;
  logic [35:0]     win_s;
  logic            accept_s;
  logic            row_end_s;
  logic            fill_end_s;
  logic            frame_end_s;
  logic            window_ok_s;
  logic [3:0]      lb0_tail_s;
  logic [3:0]      lb1_tail_s;

  // Handshake qualification and position decodes for the pixel on the bus.
  always_comb begin
    // A frame_start in the same cycle always wins over the offered pixel.
    accept_s    = pixel_valid && pixel_ready && !frame_start;
    row_end_s   = (col_r == COL_LAST);
    fill_end_s  = row_end_s && (row_r == ROW_ONE);
    frame_end_s = row_end_s && (row_r == ROW_LAST);
    // Only windows lying wholly inside the current rows are emitted.
    window_ok_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
    lb0_tail_s  = lb0_r[IMG_WIDTH-1];
    lb1_tail_s  = lb1_r[IMG_WIDTH-1];
    // Shift every window row one column left; the new right column is
    // {two rows up, one row up, current pixel} from top to bottom.
    win_s = {pixel_in,   win_r[35:32], win_r[31:28],
             lb1_tail_s, win_r[23:20], win_r[19:16],
             lb0_tail_s, win_r[11:8],  win_r[7:4]};
  end

  // Frame sequencing next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) state_s = FILL;
        else             state_s = IDLE;
      end
      FILL: begin
        if (frame_start)                  state_s = FILL;
        else if (accept_s && fill_end_s)  state_s = STREAM;
        else                              state_s = FILL;
      end
      STREAM: begin
        if (frame_start)                  state_s = FILL;
        else if (accept_s && frame_end_s) state_s = DONE;
        else                              state_s = STREAM;
      end
      DONE: begin
        if (frame_start) state_s = FILL;
        else             state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (n_rst) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Column/row position of the next pixel; cleared on restart and after the last pixel.
  always_ff @(posedge clk) begin
    if (n_rst || frame_start) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (row_end_s) begin
        col_r <= '0;
        if (frame_end_s) row_r <= '0;
        else             row_r <= row_r + 1'b1;
      end else begin
        col_r <= col_r + 1'b1;
      end
    end
  end

  // Line buffer shift chains and the working 3x3 window, advanced per accept.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0_r[i] <= 4'h0;
        lb1_r[i] <= 4'h0;
      end
      win_r <= 36'h0;
    end else if (accept_s) begin
      lb1_r[0] <= pixel_in;
      lb0_r[0] <= lb1_tail_s;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1_r[i] <= lb1_r[i-1];
        lb0_r[i] <= lb0_r[i-1];
      end
      win_r <= win_s;
    end
  end

  // Registered outputs; sample_out holds its value between valid windows.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      pixel_ready <= 1'b0;
      frame_done  <= 1'b0;
      conv_en     <= 1'b0;
      sample_out  <= 36'h0;
    end else begin
      pixel_ready <= (state_s == FILL) || (state_s == STREAM);
      frame_done  <= (state_s == DONE);
      conv_en     <= accept_s && window_ok_s;
      if (accept_s && window_ok_s) sample_out <= win_s;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a 4x4 instance driven with directed
// frames and an 8x8 instance fed a random frame checked against a 2-D model.
module tb_conv_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, fs4, pv4, pr4, ce4, fd4;
  logic [3:0]  pin4;
  logic [35:0] so4;
  logic        rst8, fs8, pv8, pr8, ce8, fd8;
  logic [3:0]  pin8;
  logic [35:0] so8;

  conv_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .n_rst(rst4), .frame_start(fs4), .pixel_in(pin4),
    .pixel_valid(pv4), .pixel_ready(pr4), .sample_out(so4),
    .conv_en(ce4), .frame_done(fd4)
  );

  conv_window_gen dut8 (
    .clk(clk), .n_rst(rst8), .frame_start(fs8), .pixel_in(pin8),
    .pixel_valid(pv8), .pixel_ready(pr8), .sample_out(so8),
    .conv_en(ce8), .frame_done(fd8)
  );

  int tests = 0;
  int fails = 0;
  int ce_cnt4 = 0;
  int ce_cnt8 = 0;
  logic [35:0] exp4[$];
  logic [35:0] exp8[$];
  logic [3:0]  img[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Hand-computed 4x4 windows: forward frame pixel k = k, reversed frame pixel k = 15-k.
  function automatic logic [35:0] win4(input int k, input bit rev);
    if (!rev) begin
      case (k)
        10: return 36'hA98654210;
        11: return 36'hBA9765321;
        14: return 36'hEDCA98654;
        15: return 36'hFEDBA9765;
        default: return 36'h0;
      endcase
    end else begin
      case (k)
        10: return 36'h5679ABDEF;
        11: return 36'h45689ACDE;
        14: return 36'h1235679AB;
        15: return 36'h01245689A;
        default: return 36'h0;
      endcase
    end
  endfunction

  // Monitor for the 4x4 instance: every conv_en pops one expected window.
  always @(negedge clk) begin
    if (ce4 === 1'b1) begin
      ce_cnt4++;
      if (exp4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL win4: conv_en with empty queue, sample_out=%h", so4);
      end else begin
        check("win4", so4, exp4.pop_front());
      end
    end
  end

  // Monitor for the 8x8 instance.
  always @(negedge clk) begin
    if (ce8 === 1'b1) begin
      ce_cnt8++;
      if (exp8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL win8: conv_en with empty queue, sample_out=%h", so8);
      end else begin
        check("win8", so8, exp8.pop_front());
      end
    end
  end

  // frame_start pulse on the 4x4 instance, optionally with a pixel offered alongside.
  task automatic start4(input bit offer);
    fs4 = 1'b1; pv4 = offer; pin4 = 4'h7;
    @(negedge clk);
    check("start_no_conv", ce4, 1'b0);
    fs4 = 1'b0; pv4 = 1'b0;
  endtask

  // Stream the first n pixels of a 4x4 frame, optionally with idle gaps.
  task automatic frame4(input int n, input bit gap, input bit rev);
    bit drop = 1'b0;
    int base = ce_cnt4;
    int nexp = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 10 || k == 11 || k == 14 || k == 15) begin
        exp4.push_back(win4(k, rev));
        nexp++;
      end
      pv4 = 1'b1;
      pin4 = rev ? 4'(15 - k) : 4'(k);
      if (pr4 !== 1'b1) drop = 1'b1;
      @(negedge clk);
      pv4 = 1'b0;
      check($sformatf("conv_en[%0d]", k), ce4, (k / 4 >= 2) && (k % 4 >= 2));
      check($sformatf("frame_done[%0d]", k), fd4, k == 15);
      if (gap) begin
        @(negedge clk);
        check($sformatf("gap_conv_en[%0d]", k), ce4, 1'b0);
      end
    end
    @(negedge clk);
    check("ready_held", drop, 1'b0);
    check("conv_count4", ce_cnt4 - base, nexp);
  endtask

  // Random 8x8 frame checked against a direct 3x3 extraction from the image.
  task automatic frame8();
    int base = ce_cnt8;
    logic [35:0] w;
    fs8 = 1'b1;
    @(negedge clk);
    fs8 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      int r = k / 8;
      int c = k % 8;
      img[k] = 4'($urandom_range(0, 15));
      if (r >= 2 && c >= 2) begin
        w = 36'h0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            w[(3*rr+cc)*4 +: 4] = img[(r-2+rr)*8 + (c-2+cc)];
        exp8.push_back(w);
      end
      pv8 = 1'b1;
      pin8 = img[k];
      @(negedge clk);
      pv8 = 1'b0;
      check($sformatf("conv_en8[%0d]", k), ce8, (r >= 2) && (c >= 2));
      check($sformatf("frame_done8[%0d]", k), fd8, k == 63);
    end
    @(negedge clk);
    check("conv_count8", ce_cnt8 - base, 36);
  endtask

  initial begin
    rst4 = 1'b1; fs4 = 1'b0; pv4 = 1'b0; pin4 = 4'h0;
    rst8 = 1'b1; fs8 = 1'b0; pv8 = 1'b0; pin8 = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", pr4, 1'b0);
    check("rst_conv", ce4, 1'b0);
    check("rst_done", fd4, 1'b0);
    check("rst_sample", so4, 36'h0);
    rst4 = 1'b0; rst8 = 1'b0;

    // Pixels offered in IDLE without frame_start are ignored.
    pv4 = 1'b1; pin4 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", pr4, 1'b0);
      check("idle_conv", ce4, 1'b0);
    end
    pv4 = 1'b0;

    // Back-to-back frame, then the same frame with alternating idle cycles.
    start4(1'b0);
    frame4(16, 1'b0, 1'b0);
    start4(1'b0);
    frame4(16, 1'b1, 1'b0);

    // Mid-frame reset after 6 pixels, then a clean frame.
    start4(1'b0);
    frame4(6, 1'b0, 1'b0);
    check("hold_sample", so4, 36'hFEDBA9765);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("mrst_ready", pr4, 1'b0);
    check("mrst_conv", ce4, 1'b0);
    check("mrst_done", fd4, 1'b0);
    check("mrst_sample", so4, 36'h0);
    pv4 = 1'b1;
    @(negedge clk);
    pv4 = 1'b0;
    check("mrst_idle_ready", pr4, 1'b0);
    start4(1'b0);
    frame4(16, 1'b0, 1'b0);

    // Restart in STREAM after 12 pixels, with a pixel offered on the restart cycle.
    start4(1'b0);
    frame4(12, 1'b0, 1'b0);
    start4(1'b1);
    frame4(16, 1'b0, 1'b1);

    // Default-size instance with random content.
    frame8();

    repeat (2) @(negedge clk);
    check("exp4_drained", exp4.size(), 0);
    check("exp8_drained", exp8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
